// File: rtl/rising_edge_d_flip_flop.sv
// Rising-edge D register with a parameterised width and depth, a clock enable and a synchronous reset value.
// Optional complemented output qn is compiled in when RISING_EDGE_DFF_QN_EN is defined.

module rising_edge_d_flip_flop_stage #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // rst takes priority so a reset edge always lands, even with en low
    always_ff @(posedge clk) begin
        if (rst)
            dout <= RESET_VALUE;
        else if (en)
            dout <= din;
    end

endmodule

module rising_edge_d_flip_flop #(
    parameter int          WIDTH       = 1,
    parameter int          STAGES      = 1,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
`ifdef RISING_EDGE_DFF_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("rising_edge_d_flip_flop: WIDTH %0d outside 1..64", WIDTH);
        end
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("rising_edge_d_flip_flop: STAGES %0d outside 1..16", STAGES);
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // One shared enable across all stages: the chain advances as a whole or not at all
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic [WIDTH-1:0] din;
            if (i == 0) begin : g_head
                assign din = d;
            end else begin : g_tail
                assign din = stage_q[i-1];
            end
            rising_edge_d_flip_flop_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RST_V)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .din  (din),
                .dout (stage_q[i])
            );
        end
    endgenerate

    assign q = stage_q[STAGES-1];

`ifdef RISING_EDGE_DFF_QN_EN
    assign qn = ~q;
`endif

endmodule

// File: tb/tb_rising_edge_d_flip_flop.sv
// Self-checking bench: plain DFF vector table, edge sensitivity, enable hold, 3-deep pipelines
// with mid-flight reset, and a 2-bit FSM built from two 1-bit instances.

module tb_rising_edge_d_flip_flop;

    logic clk;
    int   checks;
    int   failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // plain DFF
    logic rst1, en1, d1, q1;
    // 8-bit 3-stage pipelines, reset values A5 and 00, shared inputs
    logic       rst8, en8;
    logic [7:0] d8, q8a, q8z;
    // FSM pair
    logic rstf, w, y1, y2, ny1, ny2, z;
`ifdef RISING_EDGE_DFF_QN_EN
    logic qn1, y1n, y2n;
    logic [7:0] qn8a, qn8z;
`endif

    rising_edge_d_flip_flop #(.WIDTH(1), .STAGES(1), .RESET_VALUE(64'd0)) u1 (
        .clk(clk), .rst(rst1), .d(d1), .en(en1), .q(q1)
`ifdef RISING_EDGE_DFF_QN_EN
        , .qn(qn1)
`endif
    );

    rising_edge_d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(64'hA5)) u8a (
        .clk(clk), .rst(rst8), .d(d8), .en(en8), .q(q8a)
`ifdef RISING_EDGE_DFF_QN_EN
        , .qn(qn8a)
`endif
    );

    rising_edge_d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(64'h0)) u8z (
        .clk(clk), .rst(rst8), .d(d8), .en(en8), .q(q8z)
`ifdef RISING_EDGE_DFF_QN_EN
        , .qn(qn8z)
`endif
    );

    assign ny1 = w & ~(y1 | y2);
    assign ny2 = w & (y1 | y2);
    assign z   = y1 & ~y2;

    rising_edge_d_flip_flop #(.WIDTH(1), .STAGES(1)) u_y1 (
        .clk(clk), .rst(rstf), .d(ny1), .en(1'b1), .q(y1)
`ifdef RISING_EDGE_DFF_QN_EN
        , .qn(y1n)
`endif
    );

    rising_edge_d_flip_flop #(.WIDTH(1), .STAGES(1)) u_y2 (
        .clk(clk), .rst(rstf), .d(ny2), .en(1'b1), .q(y2)
`ifdef RISING_EDGE_DFF_QN_EN
        , .qn(y2n)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic rst;
        logic en;
        logic d;
        logic q;
    } vec_t;

    vec_t       vecs[12];
    logic       exp1_q[$];
    logic [7:0] exp8a_q[$];
    logic [7:0] exp8z_q[$];
    logic       expz_q[$];
    // in-flight contents of the 3-stage pipes, oldest (the stage driving q) at the front
    logic [7:0] pipe_a[$];
    logic [7:0] pipe_z[$];

    // drive at the falling edge, sample 1 unit after the rising edge
    task automatic pipe_edge(input logic r, input logic e, input logic [7:0] dv);
        @(negedge clk);
        rst8 = r; en8 = e; d8 = dv;
        if (r) begin
            pipe_a = '{8'hA5, 8'hA5, 8'hA5};
            pipe_z = '{8'h00, 8'h00, 8'h00};
        end else if (e) begin
            void'(pipe_a.pop_front()); pipe_a.push_back(dv);
            void'(pipe_z.pop_front()); pipe_z.push_back(dv);
        end
        exp8a_q.push_back(pipe_a[0]);
        exp8z_q.push_back(pipe_z[0]);
        @(posedge clk); #1;
        chk("pipe_a5_q", q8a, exp8a_q.pop_front());
        chk("pipe_00_q", q8z, exp8z_q.pop_front());
`ifdef RISING_EDGE_DFF_QN_EN
        chk("pipe_a5_qn", qn8a, ~q8a);
`endif
    endtask

    task automatic fsm_edge(input logic r, input logic wv, input logic ez, input logic [1:0] est);
        @(negedge clk);
        rstf = r; w = wv;
        expz_q.push_back(ez);
        @(posedge clk); #1;
        chk("fsm_z", z, expz_q.pop_front());
        chk("fsm_state", {y1, y2}, est);
`ifdef RISING_EDGE_DFF_QN_EN
        chk("fsm_y1n", y1n, ~est[1]);
`endif
    endtask

    initial begin
        checks = 0; failures = 0;
        rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'h00;
        rstf = 1'b1; w = 1'b1;

        //            rst   en    d     q after edge
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst1 = vecs[i].rst; en1 = vecs[i].en; d1 = vecs[i].d;
            exp1_q.push_back(vecs[i].q);
            @(posedge clk); #1;
            chk($sformatf("dff_vec%0d_q", i), q1, exp1_q.pop_front());
`ifdef RISING_EDGE_DFF_QN_EN
            chk($sformatf("dff_vec%0d_qn", i), qn1, ~vecs[i].q);
`endif
        end

        // edge sensitivity: q is 1 here; d changes between rising edges must not leak through
        @(negedge clk); #1;
        d1 = 1'b0;
        #2 chk("edge_hold_after_fall", q1, 1'b1);
        @(posedge clk); #1;
        chk("edge_rise_takes_0", q1, 1'b0);
        d1 = 1'b1;
        @(negedge clk); #1;
        chk("edge_fall_no_change", q1, 1'b0);
        @(posedge clk); #1;
        chk("edge_rise_takes_1", q1, 1'b1);

        // 8-bit pipelines: reset, then 11/22/33 back to back, with an enable gap
        pipe_edge(1'b1, 1'b1, 8'hFF);
        pipe_edge(1'b1, 1'b1, 8'hFF);
        chk("pipe_reset_a5", q8a, 8'hA5);
        chk("pipe_reset_00", q8z, 8'h00);
        pipe_edge(1'b0, 1'b1, 8'h11);
        pipe_edge(1'b0, 1'b1, 8'h22);
        pipe_edge(1'b0, 1'b1, 8'h33);
        chk("pipe_first_out_11", q8a, 8'h11);
        pipe_edge(1'b0, 1'b0, 8'hEE);
        pipe_edge(1'b0, 1'b0, 8'hDD);
        chk("pipe_hold_11", q8a, 8'h11);
        pipe_edge(1'b0, 1'b1, 8'h44);
        chk("pipe_out_22", q8a, 8'h22);
        pipe_edge(1'b0, 1'b1, 8'h55);
        chk("pipe_out_33", q8a, 8'h33);
        // reset with 44/55 in flight: both discarded
        pipe_edge(1'b1, 1'b0, 8'h99);
        chk("pipe_midreset_a5", q8a, 8'hA5);
        pipe_edge(1'b0, 1'b1, 8'h66);
        pipe_edge(1'b0, 1'b1, 8'h77);
        chk("pipe_postreset_still_a5", q8a, 8'hA5);
        pipe_edge(1'b0, 1'b1, 8'h88);
        chk("pipe_postreset_66", q8a, 8'h66);
        for (int i = 0; i < 6; i++)
            pipe_edge(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom));

        // FSM: w held high from reset gives a single-cycle z pulse
        fsm_edge(1'b1, 1'b1, 1'b0, 2'b00);
        fsm_edge(1'b0, 1'b1, 1'b1, 2'b10);
        fsm_edge(1'b0, 1'b1, 1'b0, 2'b01);
        fsm_edge(1'b0, 1'b1, 1'b0, 2'b01);
        fsm_edge(1'b0, 1'b0, 1'b0, 2'b00);
        fsm_edge(1'b0, 1'b1, 1'b1, 2'b10);
        fsm_edge(1'b0, 1'b0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
